// File: rtl/cond_unit_pkg.sv
// rtl/cond_unit_pkg.sv - shared condition codes and flag bit positions for cond_unit
package cond_unit_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Q = 0;

  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

endpackage

// File: rtl/cond_unit_check.sv
// rtl/cond_unit_check.sv - combinational condition evaluator cond_check
// NZCV is ordered {N,Z,C,V}; the NV encoding is treated as unconditional.
module cond_check
  import cond_unit_pkg::*;
(
  input  logic [3:0] CondE,
  input  logic [3:0] NZCV,
  output logic       pass
);

  logic n, z, c, v;

  always_comb begin
    n = NZCV[3];
    z = NZCV[2];
    c = NZCV[1];
    v = NZCV[0];
    pass = 1'b1;
    case (CondE)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - execute-stage condition unit: flag registers, sticky Q, gated enables
module cond_unit
  import cond_unit_pkg::*;
#(
  parameter logic [3:0] NZCV_RESET = 4'b0000,
  parameter logic       Q_RESET    = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ValidE,
  input  logic       StallE,
  input  logic       FlushE,
  input  logic [3:0] CondE,
  input  logic [1:0] FlagWE,
  input  logic       QWriteE,
  input  logic       ClrQE,
  input  logic [4:0] ALUFlags,
  input  logic       RegWriteE,
  input  logic       MemWriteE,
  input  logic       PCSrcE,
  output logic       RegWriteGE,
  output logic       MemWriteGE,
  output logic       PCSrcGE,
  output logic       CondExE,
  output logic [4:0] FlagsOut
);

  logic [3:0] nzcv_q, nzcv_d;
  logic       q_q, q_d;
  logic       live, pass, upd;

  cond_check u_cond_check (
    .CondE (CondE),
    .NZCV  (nzcv_q),
    .pass  (pass)
  );

  // Condition uses only the registered flags; ALUFlags never bypass into it.
  always_comb begin
    live       = ValidE & ~FlushE & ~reset;
    CondExE    = live & pass;
    RegWriteGE = RegWriteE & CondExE;
    MemWriteGE = MemWriteE & CondExE;
    PCSrcGE    = PCSrcE & CondExE;
    upd        = CondExE & ~StallE;

    nzcv_d = nzcv_q;
    if (upd && FlagWE[FW_NZ]) begin
      nzcv_d[3] = ALUFlags[FLAG_N];
      nzcv_d[2] = ALUFlags[FLAG_Z];
    end
    if (upd && FlagWE[FW_CV]) begin
      nzcv_d[1] = ALUFlags[FLAG_C];
      nzcv_d[0] = ALUFlags[FLAG_V];
    end

    // Saturation set takes priority over an explicit clear in the same cycle.
    q_d = q_q;
    if (upd && QWriteE && ALUFlags[FLAG_Q]) begin
      q_d = 1'b1;
    end else if (upd && ClrQE) begin
      q_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nzcv_q <= NZCV_RESET;
      q_q    <= Q_RESET;
    end else begin
      nzcv_q <= nzcv_d;
      q_q    <= q_d;
    end
  end

  assign FlagsOut = {nzcv_q, q_q};

endmodule

// File: tb/tb_cond_unit.sv
// tb/tb_cond_unit.sv - self-checking bench for cond_unit with a flag-level reference model
module tb_cond_unit;

  logic       clk;
  logic       reset;
  logic       ValidE, StallE, FlushE;
  logic [3:0] CondE;
  logic [1:0] FlagWE;
  logic       QWriteE, ClrQE;
  logic [4:0] ALUFlags;
  logic       RegWriteE, MemWriteE, PCSrcE;
  logic       RegWriteGE, MemWriteGE, PCSrcGE, CondExE;
  logic [4:0] FlagsOut;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] m_nzcv;
  logic       m_q;

  cond_unit dut (
    .clk        (clk),
    .reset      (reset),
    .ValidE     (ValidE),
    .StallE     (StallE),
    .FlushE     (FlushE),
    .CondE      (CondE),
    .FlagWE     (FlagWE),
    .QWriteE    (QWriteE),
    .ClrQE      (ClrQE),
    .ALUFlags   (ALUFlags),
    .RegWriteE  (RegWriteE),
    .MemWriteE  (MemWriteE),
    .PCSrcE     (PCSrcE),
    .RegWriteGE (RegWriteGE),
    .MemWriteGE (MemWriteGE),
    .PCSrcGE    (PCSrcGE),
    .CondExE    (CondExE),
    .FlagsOut   (FlagsOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Codes come in complementary pairs: bit 0 inverts the base test of the pair.
  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, b;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cy;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cy && !z;
      3'd5: b = (n == v);
      3'd6: b = !z && (n == v);
      default: return 1'b1;
    endcase
    return c[0] ? !b : b;
  endfunction

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%04b expected=%04b", tag, obs, exp);
    end
  endtask

  task automatic check5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%05b expected=%05b", tag, obs, exp);
    end
  endtask

  task automatic set_instr(input logic [3:0] c, input logic [1:0] fwe, input logic [4:0] alu,
                           input logic rw, input logic mw, input logic pc);
    ValidE = 1'b1; StallE = 1'b0; FlushE = 1'b0;
    CondE = c; FlagWE = fwe; ALUFlags = alu;
    QWriteE = 1'b0; ClrQE = 1'b0;
    RegWriteE = rw; MemWriteE = mw; PCSrcE = pc;
  endtask

  // Check combinational outputs against the model mid-cycle, then clock and advance the model.
  task automatic cycle(input string tag);
    logic ce;
    #3;
    ce = ValidE && !FlushE && !reset && ref_pass(CondE, m_nzcv);
    check5({tag, ".flags"}, FlagsOut, {m_nzcv, m_q});
    check1({tag, ".condex"}, CondExE, ce);
    check1({tag, ".regwr"}, RegWriteGE, ce && RegWriteE);
    check1({tag, ".memwr"}, MemWriteGE, ce && MemWriteE);
    check1({tag, ".pcsrc"}, PCSrcGE, ce && PCSrcE);
    if (reset) begin
      m_nzcv = 4'b0000;
      m_q    = 1'b0;
    end else if (ce && !StallE) begin
      if (FlagWE[1]) {m_nzcv[3], m_nzcv[2]} = ALUFlags[4:3];
      if (FlagWE[0]) {m_nzcv[1], m_nzcv[0]} = ALUFlags[2:1];
      if (QWriteE && ALUFlags[0]) m_q = 1'b1;
      else if (ClrQE) m_q = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_flags(input logic [3:0] f);
    set_instr(4'b1110, 2'b11, {f, 1'b0}, 1'b0, 1'b0, 1'b0);
    cycle("load");
  endtask

  initial begin
    m_nzcv = 4'b0000;
    m_q    = 1'b0;
    reset  = 1'b1;
    set_instr(4'b1110, 2'b11, 5'b11111, 1'b1, 1'b1, 1'b1);
    QWriteE = 1'b1;

    // Reset held for two cycles, with a live AL instruction present
    @(posedge clk); #1;
    check5("reset.flags", FlagsOut, 5'b00000);
    check1("reset.condex", CondExE, 1'b0);
    check1("reset.regwr", RegWriteGE, 1'b0);
    cycle("reset2");
    reset = 1'b0;

    // Flag write then next-cycle use
    set_instr(4'b1110, 2'b11, 5'b01100, 1'b0, 1'b0, 1'b0);
    cycle("wr_zc");
    set_instr(4'b0000, 2'b00, 5'b00000, 1'b1, 1'b0, 1'b0);
    #1 check1("eq_after_z.regwr", RegWriteGE, 1'b1);
    cycle("eq_after_z");
    set_instr(4'b1000, 2'b00, 5'b00000, 1'b1, 1'b0, 1'b0);
    #1 check1("hi_zc.condex", CondExE, 1'b0);
    check1("hi_zc.regwr", RegWriteGE, 1'b0);
    cycle("hi_zc");

    // Partial flag writes
    load_flags(4'b1001);
    set_instr(4'b1110, 2'b10, 5'b01000, 1'b0, 1'b0, 1'b0);
    cycle("wr_nz");
    check4("partial_nz", FlagsOut[4:1], 4'b0101);
    load_flags(4'b1001);
    set_instr(4'b1110, 2'b01, 5'b00100, 1'b0, 1'b0, 1'b0);
    cycle("wr_cv");
    check4("partial_cv", FlagsOut[4:1], 4'b1010);
    set_instr(4'b1110, 2'b00, 5'b11111, 1'b0, 1'b0, 1'b0);
    cycle("wr_none");
    check4("fwe00_hold", FlagsOut[4:1], 4'b1010);

    // Sticky Q
    set_instr(4'b1110, 2'b00, 5'b00001, 1'b0, 1'b0, 1'b0); QWriteE = 1'b1;
    cycle("q_set");
    check1("q_set", FlagsOut[0], 1'b1);
    set_instr(4'b1110, 2'b00, 5'b00000, 1'b0, 1'b0, 1'b0); QWriteE = 1'b1;
    cycle("q_sticky");
    check1("q_sticky", FlagsOut[0], 1'b1);
    set_instr(4'b1110, 2'b00, 5'b00000, 1'b0, 1'b0, 1'b0); ClrQE = 1'b1;
    cycle("q_clr");
    check1("q_clr", FlagsOut[0], 1'b0);
    set_instr(4'b1110, 2'b00, 5'b00001, 1'b0, 1'b0, 1'b0); ClrQE = 1'b1; QWriteE = 1'b1;
    cycle("q_setclr");
    check1("q_set_wins", FlagsOut[0], 1'b1);

    // Stall for three cycles, then a single update
    load_flags(4'b0000);
    set_instr(4'b1110, 2'b11, 5'b10000, 1'b0, 1'b0, 1'b0); StallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle("stall");
      check4("stall_hold", FlagsOut[4:1], 4'b0000);
    end
    StallE = 1'b0;
    cycle("unstall");
    check4("unstall_update", FlagsOut[4:1], 4'b1000);

    // Flush squashes flags and enables
    set_instr(4'b1110, 2'b11, 5'b01110, 1'b1, 1'b1, 1'b1); FlushE = 1'b1;
    #1 check1("flush.memwr", MemWriteGE, 1'b0);
    cycle("flush");
    check4("flush_hold", FlagsOut[4:1], 4'b1000);

    // Reset during a pending update discards it
    set_instr(4'b1110, 2'b11, 5'b11111, 1'b1, 1'b1, 1'b1); reset = 1'b1;
    cycle("reset_mid");
    check5("reset_mid", FlagsOut, 5'b00000);
    reset = 1'b0;

    // Named corner conditions
    load_flags(4'b1000);
    set_instr(4'b1011, 2'b00, 5'b00000, 1'b0, 1'b0, 1'b0);
    #1 check1("lt_n1v0", CondExE, 1'b1);
    cycle("lt");
    load_flags(4'b1001);
    set_instr(4'b1100, 2'b00, 5'b00000, 1'b0, 1'b0, 1'b0);
    #1 check1("gt_z0nv1", CondExE, 1'b1);
    cycle("gt");

    // Full sweep: every flag value against every condition code
    for (int f = 0; f < 16; f++) begin
      load_flags(4'(f));
      for (int c = 0; c < 16; c++) begin
        set_instr(4'(c), 2'b00, 5'b00000, 1'b1, 1'b1, 1'b1);
        cycle("sweep");
      end
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 31) == 0);
      ValidE    = ($urandom_range(0, 7) != 0);
      StallE    = ($urandom_range(0, 3) == 0);
      FlushE    = ($urandom_range(0, 7) == 0);
      CondE     = 4'($urandom);
      FlagWE    = 2'($urandom);
      QWriteE   = 1'($urandom);
      ClrQE     = 1'($urandom);
      ALUFlags  = 5'($urandom);
      RegWriteE = 1'($urandom);
      MemWriteE = 1'($urandom);
      PCSrcE    = 1'($urandom);
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
